rr_arb_lock: RTL and testbench

RR_ARB_LOCK -- requirements
Module: rr_arb_lock

---
 rtl/rr_arb_lock.sv | 155 +++++++++++++++
 tb/tb_rr_arb_lock.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/rr_arb_lock.sv
// rr_arb_lock: round-robin arbiter with per-requester grant locking.
//
// A one-hot priority pointer selects where the cyclic search for the next
// requester starts. A granted requester may hold the grant for extra
// accepted beats by asserting its lock bit, bounded by MAX_LOCK (0 means
// unbounded). On release, the pointer moves one past the released holder and
// a new grant is chosen in the same cycle, so back-to-back grants have no
// bubble. All outputs come straight from flops.
//
// Ports
//   clk_i         : clock, rising edge
//   rst_i         : synchronous active-high reset
//   req_i         : request vector, bit n = requester n
//   lock_i        : bit n asks to keep the grant past the current beat
//   gnt_ready_i   : downstream accepts the current grant this cycle
//   grant_o       : registered one-hot grant (or zero)
//   grant_idx_o   : binary index of grant_o (0 when no grant)
//   grant_valid_o : high exactly when grant_o is nonzero
module rr_arb_lock #(
  parameter int ARB_WIDTH = 8,
  parameter int MAX_LOCK  = 4,
  localparam int IDX_W    = $clog2(ARB_WIDTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ARB_WIDTH-1:0] req_i,
  input  logic [ARB_WIDTH-1:0] lock_i,
  input  logic                 gnt_ready_i,
  output logic [ARB_WIDTH-1:0] grant_o,
  output logic [IDX_W-1:0]     grant_idx_o,
  output logic                 grant_valid_o
);

  // With an unbounded lock the counter is never consulted; one bit suffices.
  localparam int CNT_W = (MAX_LOCK > 0) ? $clog2(MAX_LOCK + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state_q, state_d;
  logic [ARB_WIDTH-1:0]   pri_q, pri_d;
  logic [ARB_WIDTH-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
  logic                   grant_valid_q, grant_valid_d;
  logic [CNT_W-1:0]       lock_cnt_q, lock_cnt_d;

  // First set bit of req searching cyclically upward from the one-hot pri
  // position, pri position included. Zero when req is zero.
  function automatic logic [ARB_WIDTH-1:0] rr_pick(
    input logic [ARB_WIDTH-1:0] req,
    input logic [ARB_WIDTH-1:0] pri
  );
    logic [ARB_WIDTH-1:0] res;
    logic                 found;
    int                   k;
    res   = '0;
    found = 1'b0;
    for (int p = 0; p < ARB_WIDTH; p++) begin
      if (pri[p]) begin
        for (int i = 0; i < ARB_WIDTH; i++) begin
          k = (p + i) % ARB_WIDTH;
          if (!found && req[k]) begin
            res[k] = 1'b1;
            found  = 1'b1;
          end
        end
      end
    end
    return res;
  endfunction

  function automatic logic [IDX_W-1:0] onehot_to_idx(
    input logic [ARB_WIDTH-1:0] oh
  );
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_WIDTH; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  logic                 accept;
  logic                 lock_ok;
  logic                 cnt_room;
  logic [ARB_WIDTH-1:0] pri_rot;
  logic [ARB_WIDTH-1:0] pick_idle;
  logic [ARB_WIDTH-1:0] pick_next;

  always_comb begin
    accept    = grant_valid_q && gnt_ready_i;
    cnt_room  = (MAX_LOCK == 0) || (lock_cnt_q < CNT_W'(MAX_LOCK));
    lock_ok   = lock_i[grant_idx_q] && req_i[grant_idx_q] && cnt_room;
    // Pointer lands just past the releasing holder, so it is searched last.
    pri_rot   = {grant_q[ARB_WIDTH-2:0], grant_q[ARB_WIDTH-1]};
    pick_idle = rr_pick(req_i, pri_q);
    pick_next = rr_pick(req_i, pri_rot);

    state_d       = state_q;
    pri_d         = pri_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    lock_cnt_d    = lock_cnt_q;

    case (state_q)
      IDLE: begin
        if (req_i != '0) begin
          grant_d       = pick_idle;
          grant_idx_d   = onehot_to_idx(pick_idle);
          grant_valid_d = 1'b1;
          state_d       = BUSY;
        end
      end
      BUSY: begin
        if (accept) begin
          if (lock_ok) begin
            // Unbounded locks saturate instead of wrapping.
            if (lock_cnt_q != '1) lock_cnt_d = lock_cnt_q + 1'b1;
          end else begin
            pri_d         = pri_rot;
            lock_cnt_d    = '0;
            grant_d       = pick_next;
            grant_idx_d   = onehot_to_idx(pick_next);
            grant_valid_d = (req_i != '0);
            state_d       = (req_i != '0) ? BUSY : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      pri_q         <= ARB_WIDTH'(1);
      grant_q       <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      lock_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      pri_q         <= pri_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      lock_cnt_q    <= lock_cnt_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_idx_o   = grant_idx_q;
  assign grant_valid_o = grant_valid_q;

endmodule

// File: tb/tb_rr_arb_lock.sv
// Testbench for rr_arb_lock (ARB_WIDTH=4, MAX_LOCK=2): directed scenarios
// plus randomized traffic, checked against an integer-level reference model.
module tb_rr_arb_lock;

  localparam int N  = 4;
  localparam int ML = 2;
  localparam int IW = $clog2(N);

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  lock;
  logic          rdy;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic          grant_valid;

  int n_checks;
  int n_fail;

  // Reference model: holder index (-1 = none), pointer index, lock count.
  int m_gnt;
  int m_ptr;
  int m_cnt;

  rr_arb_lock #(.ARB_WIDTH(N), .MAX_LOCK(ML)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .lock_i       (lock),
    .gnt_ready_i  (rdy),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx),
    .grant_valid_o(grant_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int m_pick(input logic [N-1:0] r, input int start);
    for (int i = 0; i < N; i++) begin
      if (r[(start + i) % N]) return (start + i) % N;
    end
    return -1;
  endfunction

  task automatic model_update(input logic r_rst, input logic [N-1:0] r,
                              input logic [N-1:0] l, input logic rd);
    if (r_rst) begin
      m_gnt = -1; m_ptr = 0; m_cnt = 0;
    end else if (m_gnt < 0) begin
      m_gnt = m_pick(r, m_ptr);
    end else if (rd) begin
      if (l[m_gnt] && r[m_gnt] && m_cnt < ML) begin
        m_cnt++;
      end else begin
        m_ptr = (m_gnt + 1) % N;
        m_cnt = 0;
        m_gnt = m_pick(r, m_ptr);
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] eg;
    eg = (m_gnt < 0) ? '0 : N'(1 << m_gnt);
    chk({tag, "_grant"}, 32'(grant), 32'(eg));
    chk({tag, "_idx"},   32'(grant_idx), (m_gnt < 0) ? 32'd0 : 32'(m_gnt));
    chk({tag, "_valid"}, 32'(grant_valid), 32'(m_gnt >= 0));
    chk({tag, "_pri"},   32'(dut.pri_q), 32'(1 << m_ptr));
    chk({tag, "_cnt"},   32'(dut.lock_cnt_q), 32'(m_cnt));
  endtask

  // Drive inputs, clock once, update the model and compare after the edge.
  task automatic step(input logic r_rst, input logic [N-1:0] r,
                      input logic [N-1:0] l, input logic rd, input string tag);
    rst = r_rst; req = r; lock = l; rdy = rd;
    @(posedge clk);
    model_update(r_rst, r, l, rd);
    #1;
    check_model(tag);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    m_gnt = -1; m_ptr = 0; m_cnt = 0;
    rst = 1'b1; req = '0; lock = '0; rdy = 1'b0;
    @(negedge clk);

    // Reset state
    step(1'b1, 4'b1111, 4'b1111, 1'b1, "rst");
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_valid", 32'(grant_valid), 32'd0);
    chk("rst_pri", 32'(dut.pri_q), 32'd1);

    // Round robin
    step(1'b0, 4'b1010, 4'b0000, 1'b1, "rr0"); chk("rr0_g", 32'(grant), 32'b0010); chk("rr0_i", 32'(grant_idx), 32'd1);
    step(1'b0, 4'b1010, 4'b0000, 1'b1, "rr1"); chk("rr1_g", 32'(grant), 32'b1000); chk("rr1_i", 32'(grant_idx), 32'd3);
    step(1'b0, 4'b1010, 4'b0000, 1'b1, "rr2"); chk("rr2_g", 32'(grant), 32'b0010); chk("rr2_i", 32'(grant_idx), 32'd1);
    step(1'b0, 4'b1010, 4'b0000, 1'b1, "rr3"); chk("rr3_g", 32'(grant), 32'b1000); chk("rr3_i", 32'(grant_idx), 32'd3);

    // Stall
    step(1'b1, 4'b0000, 4'b0000, 1'b0, "st_rst");
    step(1'b0, 4'b0001, 4'b0000, 1'b0, "st0"); chk("st0_g", 32'(grant), 32'b0001);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b0100, 4'b0000, 1'b0, "st_hold");
      chk("st_hold_g", 32'(grant), 32'b0001);
      chk("st_hold_v", 32'(grant_valid), 32'd1);
    end
    step(1'b0, 4'b0100, 4'b0000, 1'b1, "st_go"); chk("st_go_g", 32'(grant), 32'b0100);

    // Bounded lock: three accepted beats on requester 0, then requester 1
    step(1'b1, 4'b0000, 4'b0000, 1'b0, "lk_rst");
    step(1'b0, 4'b0011, 4'b0001, 1'b1, "lk0"); chk("lk0_g", 32'(grant), 32'b0001);
    step(1'b0, 4'b0011, 4'b0001, 1'b1, "lk1"); chk("lk1_g", 32'(grant), 32'b0001);
    step(1'b0, 4'b0011, 4'b0001, 1'b1, "lk2"); chk("lk2_g", 32'(grant), 32'b0001);
    step(1'b0, 4'b0011, 4'b0001, 1'b1, "lk3"); chk("lk3_g", 32'(grant), 32'b0010);
    chk("lk3_pri", 32'(dut.pri_q), 32'b0010);

    // Single shot to idle, then pointer wrap
    step(1'b1, 4'b0000, 4'b0000, 1'b0, "ss_rst");
    step(1'b0, 4'b0100, 4'b0000, 1'b1, "ss0"); chk("ss0_g", 32'(grant), 32'b0100);
    step(1'b0, 4'b0000, 4'b0000, 1'b1, "ss1"); chk("ss1_g", 32'(grant), 32'd0);
    chk("ss1_v", 32'(grant_valid), 32'd0);
    chk("ss1_pri", 32'(dut.pri_q), 32'b1000);
    step(1'b0, 4'b0001, 4'b0000, 1'b1, "wr0"); chk("wr0_g", 32'(grant), 32'b0001);
    step(1'b0, 4'b0000, 4'b0000, 1'b1, "wr1"); chk("wr1_pri", 32'(dut.pri_q), 32'b0010);

    // Reset mid-operation while locked
    step(1'b1, 4'b0000, 4'b0000, 1'b0, "rm_rst0");
    step(1'b0, 4'b0100, 4'b0100, 1'b1, "rm0"); chk("rm0_g", 32'(grant), 32'b0100);
    step(1'b0, 4'b0100, 4'b0100, 1'b1, "rm1"); chk("rm1_g", 32'(grant), 32'b0100);
    step(1'b1, 4'b0100, 4'b0100, 1'b1, "rm_rst1"); chk("rm_rst1_g", 32'(grant), 32'd0);
    step(1'b0, 4'b1111, 4'b0000, 1'b1, "rm2"); chk("rm2_g", 32'(grant), 32'b0001);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 99) == 0), N'($urandom), N'($urandom),
           ($urandom_range(0, 3) != 0), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
